wb_stall_bus_if: RTL and testbench



---
 rtl/wb_stall_bus_if.sv | 151 +++++++++++++++
 tb/tb_wb_stall_bus_if.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stall_bus_if.sv
// Wishbone B3 classic master for one pipeline memory port.
// Freezes the owning stage via stallreq until ack, timeout or flush ends the transfer.
module wb_stall_bus_if #(
    parameter int unsigned STALL_BIT = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_timeout_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {StIdle, StBusy, StWaitStall} state_e;

    localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        stb_q, stb_d;
    logic        cyc_q, cyc_d;
    logic        tmo_q, tmo_d;
    logic        stage_stall;

    assign stage_stall = stall_i[STALL_BIT];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rbuf_d     = rbuf_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        tmo_d      = 1'b0;
        stallreq   = 1'b0;
        cpu_data_o = 32'h0;

        case (state_q)
            StIdle: begin
                if (cpu_ce_i && !flush_i) begin
                    stallreq = 1'b1;
                    adr_d    = cpu_addr_i;
                    dat_d    = cpu_data_i;
                    we_d     = cpu_we_i;
                    sel_d    = cpu_sel_i;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    cnt_d    = 16'h0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (flush_i) begin
                    // Flush wins: any ack in this cycle is dropped on the floor.
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = StIdle;
                end else if (wb_ack_i) begin
                    cpu_data_o = we_q ? 32'h0 : wb_dat_i;
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    rbuf_d     = wb_dat_i;
                    state_d    = stage_stall ? StWaitStall : StIdle;
                end else if (cnt_q == CntMax) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    rbuf_d  = 32'h0;
                    tmo_d   = 1'b1;
                    state_d = stage_stall ? StWaitStall : StIdle;
                end else begin
                    stallreq = 1'b1;
                    cnt_d    = cnt_q + 16'd1;
                end
            end
            StWaitStall: begin
                // Hold the read result until the controller lets the stage advance.
                cpu_data_o = rbuf_q;
                if (!stage_stall || flush_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rst) begin
            stallreq   = 1'b0;
            cpu_data_o = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 16'h0;
            rbuf_q  <= 32'h0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            tmo_q   <= tmo_d;
        end
    end

    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_we_o       = we_q;
    assign wb_sel_o      = sel_q;
    assign wb_stb_o      = stb_q;
    assign wb_cyc_o      = cyc_q;
    assign bus_timeout_o = tmo_q;

endmodule

// File: tb/tb_wb_stall_bus_if.sv
// Scenario bench for wb_stall_bus_if: expected read data is queued at request and popped at ack.
module tb_wb_stall_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_timeout_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_d;

    always #5 clk = ~clk;

    wb_stall_bus_if #(.STALL_BIT(3), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .cpu_ce_i     (cpu_ce_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_sel_i    (cpu_sel_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .stallreq     (stallreq),
        .bus_timeout_o(bus_timeout_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_we_o      (wb_we_o),
        .wb_sel_o     (wb_sel_o),
        .wb_stb_o     (wb_stb_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                           input logic [31:0] data);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = addr;
        cpu_we_i   = we;
        cpu_sel_i  = sel;
        cpu_data_i = data;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = '0; flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'hFFFF_FFFF;
        request(32'hABCD_0000, 1'b1, 4'hF, 32'h1111_2222);
        step(); step();
        nvec++; if (stallreq !== 1'b0) begin nerr++; $display("FAIL rst_stallreq got %0b want 0", stallreq); end
        nvec++; if (cpu_data_o !== 32'h0) begin nerr++; $display("FAIL rst_data got %h want 0", cpu_data_o); end
        nvec++; if ({wb_cyc_o, wb_stb_o, wb_we_o, bus_timeout_o} !== 4'b0) begin
            nerr++; $display("FAIL rst_ctrl got %b want 0000", {wb_cyc_o, wb_stb_o, wb_we_o, bus_timeout_o}); end
        nvec++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin
            nerr++; $display("FAIL rst_bus got %h %h %h want 0", wb_adr_o, wb_dat_o, wb_sel_o); end
        cpu_ce_i = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        request(32'h0000_1000, 1'b0, 4'hF, 32'h0);
        sb.push_back(32'hDEAD_BEEF);
        #1;
        nvec++; if (stallreq !== 1'b1) begin nerr++; $display("FAIL read_req_stall got %0b want 1", stallreq); end
        step(); cpu_ce_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nvec++; if (stallreq !== 1'b1) begin nerr++; $display("FAIL read_busy_stall[%0d] got %0b want 1", i, stallreq); end
            nvec++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110 || wb_adr_o !== 32'h0000_1000) begin
                nerr++; $display("FAIL read_busy_bus[%0d] got %b %h want 110 00001000", i, {wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o); end
            step();
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        #1;
        exp_d = sb.pop_front();
        nvec++; if (stallreq !== 1'b0) begin nerr++; $display("FAIL read_ack_stall got %0b want 0", stallreq); end
        nvec++; if (cpu_data_o !== exp_d) begin nerr++; $display("FAIL read_ack_data got %h want %h", cpu_data_o, exp_d); end
        step(); wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        #1;
        nvec++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin nerr++; $display("FAIL read_done_cyc got %b want 00", {wb_cyc_o, wb_stb_o}); end
        nvec++; if (stallreq !== 1'b0 || cpu_data_o !== 32'h0) begin
            nerr++; $display("FAIL read_idle got %0b %h want 0 0", stallreq, cpu_data_o); end
    endtask

    task automatic test_write();
        request(32'h0000_2004, 1'b1, 4'b0011, 32'h1234_5678);
        sb.push_back(32'h0);
        step(); cpu_ce_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777; end
            #1;
            nvec++; if (wb_we_o !== 1'b1 || wb_sel_o !== 4'b0011 || wb_dat_o !== 32'h1234_5678) begin
                nerr++; $display("FAIL write_bus[%0d] got %0b %b %h want 1 0011 12345678", i, wb_we_o, wb_sel_o, wb_dat_o); end
            nvec++; if (stallreq !== (i == 0)) begin nerr++; $display("FAIL write_stall[%0d] got %0b want %0b", i, stallreq, i == 0); end
            if (i == 1) begin
                exp_d = sb.pop_front();
                nvec++; if (cpu_data_o !== exp_d) begin nerr++; $display("FAIL write_data got %h want %h", cpu_data_o, exp_d); end
            end
            step();
        end
        wb_ack_i = 1'b0;
        nvec++; if (wb_cyc_o !== 1'b0) begin nerr++; $display("FAIL write_done_cyc got %0b want 0", wb_cyc_o); end
    endtask

    task automatic test_wait_stall();
        stall_i = 6'b001000;
        request(32'h0000_3000, 1'b0, 4'hF, 32'h0);
        sb.push_back(32'hCAFE_F00D);
        step(); cpu_ce_i = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        #1;
        nvec++; if (cpu_data_o !== sb[0]) begin nerr++; $display("FAIL ws_ack_data got %h want %h", cpu_data_o, sb[0]); end
        step(); wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            nvec++; if (cpu_data_o !== sb[0] || stallreq !== 1'b0) begin
                nerr++; $display("FAIL ws_hold[%0d] got %h %0b want %h 0", i, cpu_data_o, stallreq, sb[0]); end
            if (i == 3) stall_i = 6'b0;
            step();
        end
        exp_d = sb.pop_front();
        nvec++; if (cpu_data_o !== 32'h0) begin nerr++; $display("FAIL ws_idle_data got %h want 0 (held %h)", cpu_data_o, exp_d); end
    endtask

    task automatic test_flush();
        stall_i = 6'b001000;
        request(32'h0000_4000, 1'b0, 4'hF, 32'h0);
        step(); cpu_ce_i = 1'b0;
        nvec++; if (stallreq !== 1'b1) begin nerr++; $display("FAIL flush_busy_stall got %0b want 1", stallreq); end
        step();
        flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h55AA_55AA;
        #1;
        nvec++; if (stallreq !== 1'b0) begin nerr++; $display("FAIL flush_cycle_stall got %0b want 0", stallreq); end
        step(); flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        #1;
        nvec++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin nerr++; $display("FAIL flush_cyc got %b want 00", {wb_cyc_o, wb_stb_o}); end
        nvec++; if (cpu_data_o !== 32'h0 || stallreq !== 1'b0) begin
            nerr++; $display("FAIL flush_discard got %h %0b want 0 0", cpu_data_o, stallreq); end
        cpu_ce_i = 1'b1;
        #1;
        nvec++; if (stallreq !== 1'b1) begin nerr++; $display("FAIL flush_idle_accept got %0b want 1", stallreq); end
        cpu_ce_i = 1'b0; stall_i = 6'b0;
        step();
    endtask

    task automatic test_timeout();
        request(32'h0000_5000, 1'b0, 4'hF, 32'h0);
        step(); cpu_ce_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nvec++; if (stallreq !== (i < 3)) begin nerr++; $display("FAIL tmo_stall[%0d] got %0b want %0b", i, stallreq, i < 3); end
            nvec++; if (bus_timeout_o !== 1'b0 || wb_cyc_o !== 1'b1) begin
                nerr++; $display("FAIL tmo_busy[%0d] got %0b %0b want 0 1", i, bus_timeout_o, wb_cyc_o); end
            step();
        end
        nvec++; if (bus_timeout_o !== 1'b1 || {wb_cyc_o, wb_stb_o} !== 2'b00) begin
            nerr++; $display("FAIL tmo_pulse got %0b %b want 1 00", bus_timeout_o, {wb_cyc_o, wb_stb_o}); end
        step();
        nvec++; if (bus_timeout_o !== 1'b0) begin nerr++; $display("FAIL tmo_pulse_end got %0b want 0", bus_timeout_o); end
    endtask

    task automatic test_reset_mid();
        request(32'h0000_6000, 1'b1, 4'hC, 32'h9999_8888);
        step(); cpu_ce_i = 1'b0;
        rst = 1'b1;
        #1;
        nvec++; if (stallreq !== 1'b0) begin nerr++; $display("FAIL rstmid_comb got %0b want 0", stallreq); end
        step(); rst = 1'b0;
        nvec++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b0 || {wb_adr_o, wb_dat_o} !== 64'h0) begin
            nerr++; $display("FAIL rstmid_bus got %b %h %h want 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, wb_adr_o, wb_dat_o); end
        request(32'h0000_7000, 1'b0, 4'hF, 32'h0);
        sb.push_back(32'h0BAD_F00D);
        step(); cpu_ce_i = 1'b0;
        nvec++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h0000_7000) begin
            nerr++; $display("FAIL rstmid_fresh got %0b %h want 1 00007000", wb_cyc_o, wb_adr_o); end
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
        #1;
        exp_d = sb.pop_front();
        nvec++; if (cpu_data_o !== exp_d) begin nerr++; $display("FAIL rstmid_data got %h want %h", cpu_data_o, exp_d); end
        step(); wb_ack_i = 1'b0;
        nvec++; if (wb_cyc_o !== 1'b0) begin nerr++; $display("FAIL rstmid_done got %0b want 0", wb_cyc_o); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wait_stall();
        test_flush();
        test_timeout();
        test_reset_mid();
        nvec++; if (sb.size() != 0) begin nerr++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
